// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Optional signed-overflow output is enabled with SERIAL_SUBTRACTOR_OVF_EN.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int SUB_W_DEFAULT = 8;

endpackage

// File: rtl/serial_subtractor_fs_bit_cell.sv
// One-bit full subtractor: diff = x - y - bi, with borrow-out bo.
module fs_bit_cell (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic diff,
   output logic bo
);

   assign diff = x ^ y ^ bi;
   assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB first, with valid/ready on both sides.
// Define SERIAL_SUBTRACTOR_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int W  = SUB_W_DEFAULT,
   parameter int CW = $clog2(W)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] d,
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   output logic         ovf,
`endif
   output logic         bout
);

   state_t          state_r;
   state_t          state_s;
   logic [W-1:0]    a_sh_r;
   logic [W-1:0]    b_sh_r;
   logic [W-2:0]    d_sh_r;
   logic            borrow_r;
   logic [CW-1:0]   cnt_r;
   logic [W-1:0]    d_r;
   logic            bout_r;
   logic            diff_s;
   logic            bo_s;
   logic            last_s;
   logic [W-1:0]    full_d_s;

   fs_bit_cell u_cell (
      .x    (a_sh_r[0]),
      .y    (b_sh_r[0]),
      .bi   (borrow_r),
      .diff (diff_s),
      .bo   (bo_s)
   );

   assign last_s   = (cnt_r == CW'(W - 1));
   // New difference bit enters at the MSB; after W shifts the word is aligned.
   assign full_d_s = {diff_s, d_sh_r};

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) state_s = SHIFT;
            else          state_s = IDLE;
         end
         SHIFT: begin
            if (last_s) state_s = DONE;
            else        state_s = SHIFT;
         end
         DONE: begin
            if (out_ready) state_s = IDLE;
            else           state_s = DONE;
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_r)
         IDLE:    in_ready  = 1'b1;
         SHIFT:   in_ready  = 1'b0;
         DONE:    out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Operand shift registers, running borrow, bit counter and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh_r   <= '0;
         b_sh_r   <= '0;
         d_sh_r   <= '0;
         borrow_r <= 1'b0;
         cnt_r    <= '0;
         d_r      <= '0;
         bout_r   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  a_sh_r   <= a;
                  b_sh_r   <= b;
                  borrow_r <= bin;
                  cnt_r    <= '0;
               end
            end
            SHIFT: begin
               a_sh_r   <= {1'b0, a_sh_r[W-1:1]};
               b_sh_r   <= {1'b0, b_sh_r[W-1:1]};
               d_sh_r   <= full_d_s[W-1:1];
               borrow_r <= bo_s;
               cnt_r    <= cnt_r + CW'(1);
               if (last_s) begin
                  d_r    <= full_d_s;
                  bout_r <= bo_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign d    = d_r;
   assign bout = bout_r;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic ovf_r;

   // Signed overflow: borrow into the MSB cell differs from borrow out of it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_r <= 1'b0;
      end else if ((state_r == SHIFT) && last_s) begin
         ovf_r <= borrow_r ^ bo_s;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   assign ovf = ovf_r;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference.
// Honours SERIAL_SUBTRACTOR_OVF_EN when the overflow output is built in.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] d;
   logic         bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic         ovf;
`endif

   int n_cmp = 0;
   int n_err = 0;

   serial_subtractor #(.W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      .ovf       (ovf),
`endif
      .bout      (bout)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views
   task automatic ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin,
                          output logic [W-1:0] rd, output logic rbout, output logic rovf);
      int r;
      int sa;
      int sb;
      int sr;
      r     = int'(ra) - int'(rb) - int'(rbin);
      rd    = r[W-1:0];
      rbout = (r < 0);
      sa    = (int'(ra) >= (1 << (W - 1))) ? int'(ra) - (1 << W) : int'(ra);
      sb    = (int'(rb) >= (1 << (W - 1))) ? int'(rb) - (1 << W) : int'(rb);
      sr    = sa - sb - int'(rbin);
      rovf  = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
   endtask

   task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_bin,
                         input int hold, input string tag);
      logic [W-1:0] ed;
      logic         eb;
      logic         eo;
      int           lat;
      ref_sub(op_a, op_b, op_bin, ed, eb, eo);
      check_eq({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
      a        = op_a;
      b        = op_b;
      bin      = op_bin;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check_eq({tag, "_latency"}, 32'(lat), 32'(W));
      check_eq({tag, "_d"}, 32'(d), 32'(ed));
      check_eq({tag, "_bout"}, 32'(bout), 32'(eb));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check_eq({tag, "_ovf"}, 32'(ovf), 32'(eo));
`endif
      // Offer a different operand while stalled; it must be ignored.
      for (int i = 0; i < hold; i++) begin
         a        = ~op_a;
         b        = op_a;
         in_valid = 1'b1;
         tick();
         check_eq({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
         check_eq({tag, "_hold_d"}, 32'(d), 32'(ed));
         check_eq({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_eq({tag, "_release_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_release_ready"}, 32'(in_ready), 32'd1);
      check_eq({tag, "_kept_d"}, 32'(d), 32'(ed));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_acc;
      int second_acc;
      int hi_cnt;
      int guard;

      // Reset state
      tick();
      tick();
      check_eq("rst_in_ready", 32'(in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(out_valid), 32'd0);
      check_eq("rst_d", 32'(d), 32'd0);
      check_eq("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check_eq("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst_n = 1'b1;
      tick();

      // Directed cases
      run_op(8'h05, 8'h03, 1'b0, 0, "t05m03");
      run_op(8'h00, 8'h01, 1'b0, 0, "t00m01");
      run_op(8'h10, 8'h0F, 1'b1, 0, "t10m0F_b");
      run_op(8'h80, 8'h01, 1'b0, 0, "t80m01");
      run_op(8'h77, 8'h77, 1'b1, 0, "eq_bin");
      run_op(8'h00, 8'h00, 1'b0, 0, "zero");
      run_op(8'h3C, 8'h5A, 1'b1, 5, "backpressure");
      run_op(8'h01, 8'h00, 1'b0, 0, "small");

      // Throughput with both handshakes held high
      a = 8'h21; b = 8'h12; bin = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      first_acc  = -1;
      second_acc = -1;
      for (int c = 0; c < 40; c++) begin
         if (in_ready) begin
            if (first_acc < 0) first_acc = c;
            else if (second_acc < 0) second_acc = c;
         end
         tick();
      end
      check_eq("throughput", 32'(second_acc - first_acc), 32'(W + 2));
      in_valid = 1'b0;
      guard = 0;
      while (!(in_ready && !out_valid) && guard < 40) begin
         tick();
         guard++;
      end
      out_ready = 1'b0;
      check_eq("tput_drain", 32'(in_ready), 32'd1);

      // Reset in the middle of a shift
      a = 8'hF0; b = 8'h0F; bin = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
      check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
      check_eq("midrst_d", 32'(d), 32'd0);
      tick();
      rst_n = 1'b1;
      hi_cnt = 0;
      for (int c = 0; c < W + 4; c++) begin
         tick();
         if (out_valid) hi_cnt++;
      end
      check_eq("midrst_no_pulse", 32'(hi_cnt), 32'd0);
      run_op(8'hAA, 8'h55, 1'b0, 0, "after_rst");

      // Randomised operands and stall lengths
      for (int n = 0; n < 40; n++) begin
         run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), "rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
